// File: rtl/button_debounce_if.sv
// ----------------------------------------------------------------------------
// button_debounce_if
//   Groups the button-pin input and the debounced outputs of button_debounce.
//   master : board/stimulus side, drives i_but and observes the outputs
//   slave  : debouncer side, samples i_but and drives the outputs
//   i_but      WIDTH  raw button pins, active low, asynchronous
//   o_state    WIDTH  debounced level, active high
//   o_press    WIDTH  1-cycle pulse on released->pressed
//   o_release  WIDTH  1-cycle pulse on pressed->released
//   o_hold     WIDTH  long-press flag
// ----------------------------------------------------------------------------
interface button_debounce_if #(
    parameter int WIDTH = 2
);
    logic [WIDTH-1:0] i_but;
    logic [WIDTH-1:0] o_state;
    logic [WIDTH-1:0] o_press;
    logic [WIDTH-1:0] o_release;
    logic [WIDTH-1:0] o_hold;

    modport master (output i_but, input  o_state, o_press, o_release, o_hold);
    modport slave  (input  i_but, output o_state, o_press, o_release, o_hold);
endinterface

// File: rtl/button_debounce.sv
// ----------------------------------------------------------------------------
// button_debounce
//   Synchronises WIDTH raw active-low button pins, debounces each one
//   independently and produces an active-high level, one-cycle press/release
//   pulses and a long-press hold flag per button.
//   i_clk    system clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      button_debounce_if.slave (i_but in; o_state/o_press/o_release/o_hold out)
// ----------------------------------------------------------------------------

// One debounce channel: FSM, stability counter and hold counter. All outputs
// are registered.
module button_debounce_lane #(
    parameter int STABLE_CYCLES = 50000,
    parameter int HOLD_CYCLES   = 32'h7FFFFF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_p,        // synchronised, active-high pressed level
    output logic o_state,
    output logic o_press,
    output logic o_release,
    output logic o_hold
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] C_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0] H_MAX  = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] H_PRE  = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {REL, PWAIT, PRS, RWAIT} state_t;

    state_t        r_fsm;
    logic [CW-1:0] r_cnt;
    logic [HW-1:0] r_hcnt;
    logic          r_state, r_press, r_release, r_hold;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fsm     <= REL;
            r_cnt     <= '0;
            r_hcnt    <= '0;
            r_state   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_hold    <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;

            // Hold counter runs while the debounced level is pressed. r_hold is
            // set one edge early so it lines up with hcnt reaching H_MAX.
            if (r_state) begin
                if (r_hcnt != H_MAX) r_hcnt <= r_hcnt + HW'(1);
                if (r_hcnt >= H_PRE) r_hold <= 1'b1;
            end

            case (r_fsm)
                REL: begin
                    if (i_p) begin
                        r_fsm <= PWAIT;
                        r_cnt <= CW'(1);
                    end else begin
                        r_cnt <= '0;
                    end
                end
                PWAIT: begin
                    if (!i_p) begin
                        r_fsm <= REL;
                        r_cnt <= '0;
                    end else if (r_cnt == C_LAST) begin
                        r_fsm   <= PRS;
                        r_cnt   <= '0;
                        r_state <= 1'b1;
                        r_press <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                PRS: begin
                    if (!i_p) begin
                        r_fsm <= RWAIT;
                        r_cnt <= CW'(1);
                    end else begin
                        r_cnt <= '0;
                    end
                end
                RWAIT: begin
                    if (i_p) begin
                        // release bounce: stay pressed, hold state untouched
                        r_fsm <= PRS;
                        r_cnt <= '0;
                    end else if (r_cnt == C_LAST) begin
                        r_fsm     <= REL;
                        r_cnt     <= '0;
                        r_state   <= 1'b0;
                        r_release <= 1'b1;
                        r_hcnt    <= '0;   // overrides the increment above
                        r_hold    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_fsm <= REL;
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign o_state   = r_state;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_hold    = r_hold;
endmodule

module button_debounce #(
    parameter int WIDTH         = 2,
    parameter int STABLE_CYCLES = 50000,
    parameter int HOLD_CYCLES   = 32'h7FFFFF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    button_debounce_if.slave  bus
);
    // Two-flop synchroniser; resets to released (pins are active low).
    logic [WIDTH-1:0] r_s1, r_s2;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_state, w_press, w_release, w_hold;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= '1;
            r_s2 <= '1;
        end else begin
            r_s1 <= bus.i_but;
            r_s2 <= r_s1;
        end
    end

    assign w_p = ~r_s2;

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        button_debounce_lane #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .HOLD_CYCLES   (HOLD_CYCLES)
        ) u_lane (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_p       (w_p[g]),
            .o_state   (w_state[g]),
            .o_press   (w_press[g]),
            .o_release (w_release[g]),
            .o_hold    (w_hold[g])
        );
    end

    assign bus.o_state   = w_state;
    assign bus.o_press   = w_press;
    assign bus.o_release = w_release;
    assign bus.o_hold    = w_hold;
endmodule

// File: tb/tb_button_debounce.sv
// ----------------------------------------------------------------------------
// tb_button_debounce
//   Directed stimulus for button_debounce (STABLE_CYCLES=4, HOLD_CYCLES=10).
//   Stimulus pushes the expected output event (cycle, press, release, state,
//   hold) into a queue; the monitor pops and compares whenever the DUT shows
//   a press/release pulse or a hold change.
// ----------------------------------------------------------------------------
module tb_button_debounce;
    localparam int W = 2;
    localparam int S = 4;
    localparam int H = 10;
    localparam int LAT = S + 2;

    typedef struct packed {
        int         cyc;
        logic [1:0] pr;
        logic [1:0] rl;
        logic [1:0] st;
        logic [1:0] hd;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    ev_t  q[$];
    logic [1:0] prev_hd = '0;

    button_debounce_if #(.WIDTH(W)) bif ();

    button_debounce #(
        .WIDTH         (W),
        .STABLE_CYCLES (S),
        .HOLD_CYCLES   (H)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bif.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Monitor: any pulse or hold change is an output event.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hd = '0;
        end else if (|bif.o_press || |bif.o_release || bif.o_hold != prev_hd) begin
            prev_hd = bif.o_hold;
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event cyc=%0d press=%b release=%b state=%b hold=%b",
                         cyc, bif.o_press, bif.o_release, bif.o_state, bif.o_hold);
            end else begin
                ev_t e;
                e = q.pop_front();
                if (e.cyc != cyc || e.pr != bif.o_press || e.rl != bif.o_release ||
                    e.st != bif.o_state || e.hd != bif.o_hold) begin
                    n_bad++;
                    $display("FAIL event got cyc=%0d press=%b release=%b state=%b hold=%b exp cyc=%0d press=%b release=%b state=%b hold=%b",
                             cyc, bif.o_press, bif.o_release, bif.o_state, bif.o_hold,
                             e.cyc, e.pr, e.rl, e.st, e.hd);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int dt, input logic [1:0] pr, input logic [1:0] rl,
                        input logic [1:0] st, input logic [1:0] hd);
        ev_t e;
        e.cyc = cyc + dt;
        e.pr = pr; e.rl = rl; e.st = st; e.hd = hd;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] outs();
        return {bif.o_state, bif.o_press, bif.o_release, bif.o_hold};
    endfunction

    initial begin
        bif.i_but = 2'b11;
        #3 rst_n = 1'b0;

        // 1: reset with both buttons held low
        bif.i_but = 2'b00;
        step(3);
        chk("reset_outputs", outs(), 8'h00);
        rst_n = 1'b1;
        push(LAT,     2'b11, 2'b00, 2'b11, 2'b00);
        push(LAT + H, 2'b00, 2'b00, 2'b11, 2'b11);
        step(1);
        chk("post_reset_outputs", outs(), 8'h00);
        step(19);
        bif.i_but = 2'b11;
        push(LAT, 2'b00, 2'b11, 2'b00, 2'b00);
        step(10);

        // 2/4/5: clean press, 2-cycle glitch, hold, 3-cycle bounce, release
        bif.i_but = 2'b10;
        push(LAT,     2'b01, 2'b00, 2'b01, 2'b00);
        push(LAT + H, 2'b00, 2'b00, 2'b01, 2'b01);
        step(8);
        bif.i_but = 2'b11;
        step(2);
        bif.i_but = 2'b10;
        step(8);
        bif.i_but = 2'b11;
        step(3);
        bif.i_but = 2'b10;
        step(5);
        chk("hold_through_bounce", outs(), {2'b01, 2'b00, 2'b00, 2'b01});
        bif.i_but = 2'b11;
        push(LAT, 2'b00, 2'b01, 2'b00, 2'b00);
        step(10);

        // 3: bounce, then a stable press
        bif.i_but = 2'b10; step(3);
        bif.i_but = 2'b11; step(1);
        bif.i_but = 2'b10; step(3);
        bif.i_but = 2'b11; step(4);
        chk("bounce_no_state", outs(), 8'h00);
        bif.i_but = 2'b10;
        push(LAT, 2'b01, 2'b00, 2'b01, 2'b00);
        step(8);
        bif.i_but = 2'b11;
        push(LAT, 2'b00, 2'b01, 2'b00, 2'b00);
        step(10);

        // 6: simultaneous press/release on both channels
        bif.i_but = 2'b00;
        push(LAT, 2'b11, 2'b00, 2'b11, 2'b00);
        step(8);
        bif.i_but = 2'b11;
        push(LAT, 2'b00, 2'b11, 2'b00, 2'b00);
        step(10);

        // 6: reset during a PWAIT count drops the pending press
        bif.i_but = 2'b10;
        step(4);
        rst_n = 1'b0;
        #1 chk("reset_in_pwait", outs(), 8'h00);
        step(2);
        bif.i_but = 2'b11;
        rst_n = 1'b1;
        step(12);

        // reset while channel 1 is pressed clears STATE at once
        bif.i_but = 2'b01;
        push(LAT, 2'b10, 2'b00, 2'b10, 2'b00);
        step(8);
        chk("ch1_pressed", outs(), {2'b10, 2'b00, 2'b00, 2'b00});
        rst_n = 1'b0;
        #1 chk("reset_clears_state", outs(), 8'h00);
        step(2);
        bif.i_but = 2'b11;
        rst_n = 1'b1;
        step(12);

        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL missing_events got=%0d pending exp=0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
